scratch_pad_loader: RTL and testbench

- Write-side sequencer in front of the NDP scratch pad.
- Accepts a 32-bit valid/ready word stream and produces the scratch pad's wen / data_in_addr / data_in write port.
- Fills one or more 8-entry address slots across all SYS_HEIGHT+SYS_WIDTH BRAM banks.
- Pulses per-entry completion so the downstream reader knows when data_out_addr may select a slot.

---
 rtl/scratch_pad_loader.sv | 199 +++++++++++++++++++
 tb/tb_scratch_pad_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_pad_loader.sv
// scratch_pad_loader: write-side sequencer for the NDP scratch pad.
// Turns a 32-bit valid/ready word stream into registered wen / data_in_addr /
// data_in writes that fill 8-entry slots across all SYS_HEIGHT+SYS_WIDTH banks.
// Define SP_LOAD_TIMEOUT_EN to enable the stall timeout and the err pulse.
module scratch_pad_loader #(
    parameter int SYS_WIDTH  = 64,
    parameter int SYS_HEIGHT = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic        write_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  base_entry,
    input  logic [3:0]  num_entries,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        wen,
    output logic [10:0] data_in_addr,
    output logic [31:0] data_in,
    output logic        busy,
    output logic        entry_done,
    output logic [2:0]  entry_idx,
    output logic        done,
    output logic        err
);

    localparam int NUM_BANKS = SYS_HEIGHT + SYS_WIDTH;
    // Beat index within an entry is {bank, half}; the last beat is bank NUM_BANKS-1, half 1.
    localparam logic [7:0] LAST_BEAT = 8'(2 * NUM_BANKS - 1);

    generate
        if (NUM_BANKS < 1 || NUM_BANKS > 128) begin : g_bad_banks
            $error("scratch_pad_loader: SYS_HEIGHT+SYS_WIDTH must be in 1..128");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("scratch_pad_loader: TIMEOUT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  base_q, base_d;
    logic [3:0]  num_q, num_d;
    logic [3:0]  entries_q, entries_d;
    logic [7:0]  beat_q, beat_d;
    logic        wen_q, wen_d;
    logic [10:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        entry_done_q, entry_done_d;
    logic [2:0]  entry_idx_q, entry_idx_d;
    logic        done_q, done_d;
    logic [2:0]  slot;

`ifdef SP_LOAD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
`endif

    // Slot currently being filled; 3-bit add wraps 7 -> 0.
    assign slot = base_q + entries_q[2:0];

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign wen          = wen_q;
    assign data_in_addr = addr_q;
    assign data_in      = data_q;
    assign entry_done   = entry_done_q;
    assign entry_idx    = entry_idx_q;
    assign done         = done_q;
`ifdef SP_LOAD_TIMEOUT_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

    // Next-state and write-port logic: one registered write per accepted beat.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        entries_d    = entries_q;
        beat_d       = beat_q;
        wen_d        = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        entry_done_d = 1'b0;
        entry_idx_d  = entry_idx_q;
        done_d       = 1'b0;
`ifdef SP_LOAD_TIMEOUT_EN
        stall_d      = stall_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_entries == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        base_d    = base_entry;
                        num_d     = num_entries;
                        entries_d = 4'd0;
                        beat_d    = 8'd0;
                        state_d   = S_LOAD;
`ifdef SP_LOAD_TIMEOUT_EN
                        stall_d   = '0;
`endif
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    wen_d  = 1'b1;
                    addr_d = {slot, beat_q};
                    data_d = in_data;
`ifdef SP_LOAD_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (beat_q == LAST_BEAT) begin
                        entry_done_d = 1'b1;
                        entry_idx_d  = slot;
                        beat_d       = 8'd0;
                        entries_d    = entries_q + 4'd1;
                        if (entries_q + 4'd1 == num_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
`ifdef SP_LOAD_TIMEOUT_EN
                else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    stall_d = '0;
                    state_d = S_IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any load in flight.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= 3'd0;
            num_q        <= 4'd0;
            entries_q    <= 4'd0;
            beat_q       <= 8'd0;
            wen_q        <= 1'b0;
            addr_q       <= 11'd0;
            data_q       <= 32'd0;
            entry_done_q <= 1'b0;
            entry_idx_q  <= 3'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            entries_q    <= entries_d;
            beat_q       <= beat_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            entry_done_q <= entry_done_d;
            entry_idx_q  <= entry_idx_d;
            done_q       <= done_d;
        end
    end

`ifdef SP_LOAD_TIMEOUT_EN
    // Stall counter and err pulse for the timeout abort.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_scratch_pad_loader.sv
// tb_scratch_pad_loader: directed self-checking bench for scratch_pad_loader
// at default geometry (65 banks, 130 words per entry). The timeout section
// follows SP_LOAD_TIMEOUT_EN, with TIMEOUT set to 16.
module tb_scratch_pad_loader;

    localparam int WORDS = 130;

    logic        write_clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  base_entry;
    logic [3:0]  num_entries;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wen;
    logic [10:0] data_in_addr;
    logic [31:0] data_in;
    logic        busy;
    logic        entry_done;
    logic [2:0]  entry_idx;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    scratch_pad_loader #(
        .SYS_WIDTH (64),
        .SYS_HEIGHT(1),
        .TIMEOUT   (16)
    ) dut (
        .write_clk   (write_clk),
        .rst         (rst),
        .start       (start),
        .base_entry  (base_entry),
        .num_entries (num_entries),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wen         (wen),
        .data_in_addr(data_in_addr),
        .data_in     (data_in),
        .busy        (busy),
        .entry_done  (entry_done),
        .entry_idx   (entry_idx),
        .done        (done),
        .err         (err)
    );

    // Free-running 100 MHz clock.
    always #5 write_clk = ~write_clk;

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [2:0] base, input logic [3:0] num);
        start       = 1'b1;
        base_entry  = base;
        num_entries = num;
        tick();
        start = 1'b0;
    endtask

    // Streams n_entries*130 beats and checks every write one cycle after acceptance.
    task automatic drive_load(input logic [2:0] first_slot, input int n_entries,
                              input bit gaps, input bit poke_start, input logic [31:0] seed);
        int         total;
        int         written;
        int         beat;
        logic       vld;
        logic [2:0] slot;
        total   = n_entries * WORDS;
        written = 0;
        for (int cyc = 0; cyc < 2 * total + 10 && written < total; cyc++) begin
            vld      = gaps ? (cyc % 2 == 0) : 1'b1;
            in_valid = vld;
            in_data  = seed + 32'(written);
            if (poke_start && cyc == 20) begin
                start       = 1'b1;
                base_entry  = 3'd4;
                num_entries = 4'd3;
            end
            tick();
            start = 1'b0;
            check_output("wen", 32'(wen), 32'(vld));
            if (vld) begin
                beat = written % WORDS;
                slot = first_slot + 3'(written / WORDS);
                check_output("addr", 32'(data_in_addr), 32'({slot, 8'(beat)}));
                check_output("data", data_in, seed + 32'(written));
                check_output("entry_done", 32'(entry_done), 32'(beat == WORDS - 1));
                if (beat == WORDS - 1) begin
                    check_output("entry_idx", 32'(entry_idx), 32'(slot));
                end
                written++;
            end else begin
                check_output("entry_done_gap", 32'(entry_done), 32'd0);
            end
        end
        in_valid = 1'b0;
        check_output("beats_written", 32'(written), 32'(total));
    endtask

    // Final entry_done cycle is in DONE; done follows one cycle later.
    task automatic finish_check();
        check_output("done_early", 32'(done), 32'd0);
        check_output("busy_in_done", 32'(busy), 32'd1);
        tick();
        check_output("done_pulse", 32'(done), 32'd1);
        check_output("busy_after", 32'(busy), 32'd0);
        check_output("wen_after", 32'(wen), 32'd0);
        tick();
        check_output("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        base_entry  = 3'd0;
        num_entries = 4'd0;
        in_valid    = 1'b0;
        in_data     = 32'd0;
        tick();
        tick();
        check_output("rst_wen", 32'(wen), 32'd0);
        check_output("rst_addr", 32'(data_in_addr), 32'd0);
        check_output("rst_data", data_in, 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_entry_done", 32'(entry_done), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] single entry, base 2");
        start_load(3'd2, 4'd1);
        check_output("load_busy", 32'(busy), 32'd1);
        check_output("load_in_ready", 32'(in_ready), 32'd1);
        check_output("load_wen_idle", 32'(wen), 32'd0);
        drive_load(3'd2, 1, 1'b0, 1'b0, 32'h1000_0000);
        check_output("last_addr", 32'(data_in_addr), 32'h281);
        finish_check();

        $display("[TB] wrap-around, base 6, three entries");
        start_load(3'd6, 4'd3);
        drive_load(3'd6, 3, 1'b0, 1'b0, 32'h2000_0000);
        check_output("wrap_last_idx", 32'(entry_idx), 32'd0);
        finish_check();

        $display("[TB] back-pressure, alternating valid");
        start_load(3'd1, 4'd1);
        drive_load(3'd1, 1, 1'b1, 1'b0, 32'h3000_0000);
        finish_check();

        $display("[TB] zero-entry start");
        start_load(3'd5, 4'd0);
        check_output("zero_done", 32'(done), 32'd1);
        check_output("zero_busy", 32'(busy), 32'd0);
        check_output("zero_wen", 32'(wen), 32'd0);
        tick();
        check_output("zero_done_single", 32'(done), 32'd0);
        check_output("zero_busy_after", 32'(busy), 32'd0);

        $display("[TB] start while busy is ignored");
        start_load(3'd1, 4'd1);
        drive_load(3'd1, 1, 1'b0, 1'b1, 32'h4000_0000);
        finish_check();

        $display("[TB] reset mid-load");
        start_load(3'd3, 4'd2);
        for (int k = 0; k < 51; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h5000_0000 + 32'(k);
            tick();
        end
        check_output("pre_rst_addr", 32'(data_in_addr), 32'h332);
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_wen", 32'(wen), 32'd0);
        check_output("arst_addr", 32'(data_in_addr), 32'd0);
        check_output("arst_data", data_in, 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_in_ready", 32'(in_ready), 32'd0);
        check_output("arst_entry_done", 32'(entry_done), 32'd0);
        in_valid = 1'b0;
        tick();
        check_output("arst_done", 32'(done), 32'd0);
        check_output("arst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        check_output("post_rst_done", 32'(done), 32'd0);
        start_load(3'd3, 4'd1);
        drive_load(3'd3, 1, 1'b0, 1'b0, 32'h6000_0000);
        finish_check();

        $display("[TB] stall after 10 beats");
        start_load(3'd0, 4'd1);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h7000_0000 + 32'(k);
            tick();
            check_output("stall_wen", 32'(wen), 32'd1);
        end
        in_valid = 1'b0;
`ifdef SP_LOAD_TIMEOUT_EN
        repeat (15) tick();
        check_output("to_err_early", 32'(err), 32'd0);
        check_output("to_busy_early", 32'(busy), 32'd1);
        tick();
        check_output("to_err", 32'(err), 32'd1);
        check_output("to_busy", 32'(busy), 32'd0);
        check_output("to_done", 32'(done), 32'd0);
        check_output("to_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_output("to_err_single", 32'(err), 32'd0);
        check_output("to_done_after", 32'(done), 32'd0);
        check_output("to_wen_after", 32'(wen), 32'd0);
`else
        repeat (20) tick();
        check_output("wait_err", 32'(err), 32'd0);
        check_output("wait_busy", 32'(busy), 32'd1);
        check_output("wait_in_ready", 32'(in_ready), 32'd1);
        check_output("wait_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_output("wait_cleared", 32'(busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
